// File: rtl/ifm_buffer_hdshk.sv
// rtl/ifm_buffer_hdshk.sv - layer-1 feature-map capture RAM with handshaked IFM read port
module ifm_buffer_hdshk #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int CHANNELS = 16,
  parameter int DATA_W   = 16,
  parameter int AW       = 10,
  parameter int CW       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     full,
  output logic                     overflow,
  input  logic [AW-1:0]            ifm_addr,
  input  logic [CW-1:0]            ifm_chan,
  input  logic                     ifm_addr_valid,
  output logic                     ifm_addr_ready,
  output logic signed [DATA_W-1:0] ifm_data,
  output logic                     ifm_data_valid,
  input  logic                     ifm_data_ready
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int DEPTH = NPIX * CHANNELS;
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]     pix;
  logic [CW-1:0]     ch;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     rd_chan;
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic          wr_en;
  logic          pix_last;
  logic          ch_last;
  logic          rd_oob;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          unused_wr_hi;

  // Upper stream bits are discarded by design (plain truncation into the stored word)
  assign unused_wr_hi = ^wr_data[31:DATA_W];

  assign pix_last = (32'(pix) == NPIX - 1);
  assign ch_last  = (32'(ch) == CHANNELS - 1);
  assign wr_en    = wr_valid && !full && !clear && !rst;
  assign wr_idx   = IW'(ch) * IW'(NPIX) + IW'(pix);
  assign rd_idx   = IW'(rd_chan) * IW'(NPIX) + IW'(rd_addr);
  assign rd_oob   = (32'(rd_chan) >= CHANNELS) || (32'(rd_addr) >= NPIX);

  // Capture counters: raster position within a channel, then channel; full/overflow flags
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pix      <= '0;
      ch       <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else if (wr_valid) begin
      if (full) begin
        overflow <= 1'b1;
      end else if (pix_last) begin
        pix <= '0;
        if (ch_last) begin
          ch   <= '0;
          full <= 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end else begin
        pix <= pix + 1'b1;
      end
    end
  end

  // Storage write; reads only happen while full, writes only while not full, so one port suffices
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_idx] <= wr_data[DATA_W-1:0];
    end
  end

  // Latch the request so the requester may change address/channel after the acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      rd_chan <= '0;
    end else if (state == S_IDLE && ifm_addr_valid && full) begin
      rd_addr <= ifm_addr;
      rd_chan <= ifm_chan;
    end
  end

  // Registered read in the acknowledge cycle; held through DATA; out-of-range returns zero
  always_ff @(posedge clk) begin
    if (rst) begin
      ifm_data <= '0;
    end else if (!clear && state == S_ACK) begin
      ifm_data <= rd_oob ? '0 : ram[rd_idx];
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read FSM next state: requests wait until capture is complete; clear aborts any read
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ifm_addr_valid && full) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_DATA;
      S_DATA: if (ifm_data_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
    end
  end

  // Read FSM outputs: one-cycle acknowledge, then data valid until accepted
  always_comb begin
    ifm_addr_ready = 1'b0;
    ifm_data_valid = 1'b0;
    case (state)
      S_ACK:  ifm_addr_ready = 1'b1;
      S_DATA: ifm_data_valid = 1'b1;
      default: begin
        ifm_addr_ready = 1'b0;
        ifm_data_valid = 1'b0;
      end
    endcase
  end

endmodule
